din_debounce: RTL and testbench
===============================

DIN_DEBOUNCE -- requirements
Module: din_debounce

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth per channel; legal range 2..4.
REQ-002 SHALL have parameter DB_LIMIT, default 15, giving the consecutive mismatching cycles needed to accept a new level; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port in1, input, 1 bit: raw asynchronous channel 1, for example a pin or switch.
REQ-006 SHALL have port in2, input, 1 bit: raw asynchronous channel 2.
REQ-007 SHALL have port di1, output, 1 bit: debounced channel 1, driven by a register, feeding the downstream logic stage.
REQ-008 SHALL have port di2, output, 1 bit: debounced channel 2, driven by a register.
REQ-009 SHALL have port chg1, output, 1 bit: one-cycle pulse when di1 changes.
REQ-010 SHALL have port chg2, output, 1 bit: one-cycle pulse when di2 changes.

Function
REQ-011 SHALL give each channel its own chain of SYNC_STAGES flip-flops; the last stage is that channel's synchronized value s.
REQ-012 SHALL give each channel a counter of ceil(log2(DB_LIMIT+1)) bits.
REQ-013 On each edge where s equals the channel output, the counter SHALL load 0.
REQ-014 On each edge where s differs from the output and the counter is below DB_LIMIT-1, the counter SHALL increment by 1.
REQ-015 On the edge where s differs from the output and the counter equals DB_LIMIT-1, the output SHALL load s and the counter SHALL load 0.
REQ-016 SHALL treat each channel as having two states, STABLE (counter 0) and PENDING (counter >0); a mismatch moves STABLE to PENDING, and an accept or a match returns to STABLE.
REQ-017 Latency SHALL be exactly SYNC_STAGES+DB_LIMIT rising edges from the first edge that samples a new stable raw level to the output changing; the default is 17.
REQ-018 A raw pulse that produces fewer than DB_LIMIT consecutive mismatching cycles at s SHALL leave the output unchanged and the counter at 0 afterwards.
REQ-019 chgN SHALL be registered and high for exactly the one cycle after the edge on which diN updates; it SHALL be low at all other times.
REQ-020 Channels SHALL be independent; simultaneous accepts on both channels SHALL assert chg1 and chg2 in the same cycle.
REQ-021 With DB_LIMIT=1, the output SHALL follow s with a 1-cycle delay, and a single-cycle mismatch SHALL be accepted.
REQ-022 The counter SHALL never exceed DB_LIMIT-1 and SHALL never wrap around.
REQ-023 The raw inputs SHALL reach no logic other than the first synchronizer stage.

Reset
REQ-024 While rst=1, all synchronizer flops, counters, di1, di2, chg1 and chg2 SHALL be 0, asynchronously and independently of clk.
REQ-025 Reset asserted mid-PENDING SHALL discard the count; after release, a raw level of 1 SHALL again need SYNC_STAGES+DB_LIMIT edges to appear.
REQ-026 No chg pulse SHALL be generated by reset assertion or release.

Configuration
REQ-027 Macro DIN_DEBOUNCE_CHG_EN SHALL control the change-pulse logic.
REQ-028 With DIN_DEBOUNCE_CHG_EN defined, chg1 and chg2 SHALL behave per REQ-019 and REQ-020.
REQ-029 With DIN_DEBOUNCE_CHG_EN undefined, chg1 and chg2 SHALL be tied to constant 0 with no registers inferred for them; di1 and di2 behaviour SHALL be unchanged and the port list SHALL be identical.

Verification
REQ-030 Defaults; rst=1 for 3 cycles with in1=in2=1, then release -> all outputs 0 during reset; di1 and di2 rise 17 edges after release; chg1 and chg2 both high for exactly 1 cycle, the cycle after that edge.
REQ-031 Defaults; in1 pulses high for 10 cycles -> di1 stays 0, chg1 never asserts, counter back to 0.
REQ-032 Defaults; in2 rises, then drops at edge 12 for 2 cycles, then holds 1 -> di2 rises 17 edges after the final rise, not before.
REQ-033 Defaults; in1 at 1 for 8 cycles, then rst pulsed for 1 cycle, in1 still 1 -> di1 0 at reset; di1 rises 17 edges after release.
REQ-034 DB_LIMIT=1, SYNC_STAGES=3; in1 toggles every 2 cycles -> di1 reproduces the toggling delayed 4 edges; chg1 pulses on every change.
REQ-035 DIN_DEBOUNCE_CHG_EN undefined; repeat REQ-030 -> di timing identical to REQ-030; chg1 and chg2 constant 0.

Source files
------------

// File: rtl/din_debounce.sv
// Two-channel input debouncer: per-channel synchronizer chain, mismatch counter and
// registered change pulses. Define DIN_DEBOUNCE_CHG_EN to build the chg1/chg2 pulse logic.
module din_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_LIMIT    = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic in1,
  input  logic in2,
  output logic di1,
  output logic di2,
  output logic chg1,
  output logic chg2
);

  localparam int            CW       = $clog2(DB_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_LIMIT - 1);

  logic [1:0] raw;
  assign raw = {in2, in1};

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CW-1:0]          cnt;
    logic                   di_q;

    // The raw pin only ever reaches sync[0]; everything downstream sees s.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= '0;
      else     sync <= {sync[SYNC_STAGES-2:0], raw[c]};
    end

    assign s = sync[SYNC_STAGES-1];

    // cnt == 0 is the STABLE state, any other value is PENDING.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt  <= '0;
        di_q <= 1'b0;
      end else if (s == di_q) begin
        cnt  <= '0;
      end else if (cnt == CNT_LAST) begin
        di_q <= s;
        cnt  <= '0;
      end else begin
        cnt  <= cnt + CW'(1);
      end
    end
  end

  assign di1 = g_ch[0].di_q;
  assign di2 = g_ch[1].di_q;

`ifdef DIN_DEBOUNCE_CHG_EN
  logic [1:0] chg_q;

  // Set on the same edge that updates di, so the pulse occupies the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_q <= 2'b00;
    end else begin
      chg_q[0] <= (g_ch[0].s != g_ch[0].di_q) && (g_ch[0].cnt == CNT_LAST);
      chg_q[1] <= (g_ch[1].s != g_ch[1].di_q) && (g_ch[1].cnt == CNT_LAST);
    end
  end

  assign chg1 = chg_q[0];
  assign chg2 = chg_q[1];
`else
  assign chg1 = 1'b0;
  assign chg2 = 1'b0;
`endif

endmodule

// File: tb/tb_din_debounce.sv
// Directed bench for din_debounce: default instance plus a DB_LIMIT=1 / SYNC_STAGES=3 instance.
module tb_din_debounce;

`ifdef DIN_DEBOUNCE_CHG_EN
  localparam logic CHG_EN = 1'b1;
`else
  localparam logic CHG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, a_in1, a_in2, a_di1, a_di2, a_chg1, a_chg2;
  logic b_rst, b_in1, b_in2, b_di1, b_di2, b_chg1, b_chg2;

  din_debounce dut_a (
    .clk (clk), .rst (a_rst), .in1 (a_in1), .in2 (a_in2),
    .di1 (a_di1), .di2 (a_di2), .chg1 (a_chg1), .chg2 (a_chg2)
  );

  din_debounce #(.SYNC_STAGES(3), .DB_LIMIT(1)) dut_b (
    .clk (clk), .rst (b_rst), .in1 (b_in1), .in2 (b_in2),
    .di1 (b_di1), .di2 (b_di2), .chg1 (b_chg1), .chg2 (b_chg2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic pat(input int k);
    return k[1];
  endfunction

  logic seen;
  logic exp_di, prev_di;

  initial begin
    a_rst = 1'b1; a_in1 = 1'b1; a_in2 = 1'b1;
    b_rst = 1'b1; b_in1 = 1'b0; b_in2 = 1'b0;

    // Reset held 3 cycles with raw inputs high: everything stays 0.
    repeat (3) begin
      @(negedge clk);
      check("rst_di1", a_di1, 0);
      check("rst_di2", a_di2, 0);
      check("rst_chg1", a_chg1, 0);
      check("rst_chg2", a_chg2, 0);
    end
    a_rst = 1'b0;
    b_rst = 1'b0;
    repeat (16) @(negedge clk);
    check("lat16_di1", a_di1, 0);
    check("lat16_di2", a_di2, 0);
    check("lat16_chg1", a_chg1, 0);
    @(negedge clk);
    check("lat17_di1", a_di1, 1);
    check("lat17_di2", a_di2, 1);
    check("lat17_chg1", a_chg1, CHG_EN);
    check("lat17_chg2", a_chg2, CHG_EN);
    @(negedge clk);
    check("lat18_chg1", a_chg1, 0);
    check("lat18_chg2", a_chg2, 0);
    check("lat18_di1", a_di1, 1);

    // Back to a 0 baseline on both channels.
    a_in1 = 1'b0; a_in2 = 1'b0; a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    check("rerst_di1", a_di1, 0);
    check("rerst_chg1", a_chg1, 0);

    // 10-cycle high pulse on in1 is rejected.
    seen = 1'b0;
    a_in1 = 1'b1;
    repeat (10) begin @(negedge clk); seen |= a_di1 | a_chg1; end
    a_in1 = 1'b0;
    repeat (20) begin @(negedge clk); seen |= a_di1 | a_chg1; end
    check("pulse10_quiet", seen, 0);
    check("pulse10_cnt", dut_a.g_ch[0].cnt, 0);

    // 14 cycles (DB_LIMIT-1 mismatches) is still rejected.
    seen = 1'b0;
    a_in1 = 1'b1;
    repeat (14) begin @(negedge clk); seen |= a_di1 | a_chg1; end
    a_in1 = 1'b0;
    repeat (20) begin @(negedge clk); seen |= a_di1 | a_chg1; end
    check("pulse14_quiet", seen, 0);
    check("pulse14_cnt", dut_a.g_ch[0].cnt, 0);

    // 15 cycles is accepted, then the return to 0 is accepted 15 mismatches later.
    a_in1 = 1'b1;
    repeat (15) @(negedge clk);
    a_in1 = 1'b0;
    @(negedge clk);
    check("pulse15_s16_di1", a_di1, 0);
    @(negedge clk);
    check("pulse15_s17_di1", a_di1, 1);
    check("pulse15_s17_chg1", a_chg1, CHG_EN);
    check("pulse15_s17_di2", a_di2, 0);
    repeat (14) @(negedge clk);
    check("pulse15_s31_di1", a_di1, 1);
    check("pulse15_s31_chg1", a_chg1, 0);
    @(negedge clk);
    check("pulse15_s32_di1", a_di1, 0);
    check("pulse15_s32_chg1", a_chg1, CHG_EN);
    @(negedge clk);
    check("pulse15_s33_chg1", a_chg1, 0);

    // in2 rises, glitches low for 2 cycles at step 12, then holds: count restarts.
    a_in2 = 1'b1;
    repeat (12) @(negedge clk);
    a_in2 = 1'b0;
    repeat (2) @(negedge clk);
    a_in2 = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch_orig17_di2", a_di2, 0);
    repeat (13) @(negedge clk);
    check("glitch_f16_di2", a_di2, 0);
    @(negedge clk);
    check("glitch_f17_di2", a_di2, 1);
    check("glitch_f17_chg2", a_chg2, CHG_EN);
    check("glitch_f17_chg1", a_chg1, 0);

    // Reset mid-PENDING discards the count, asynchronously.
    a_in1 = 1'b1;
    repeat (8) @(negedge clk);
    check("pend_cnt", dut_a.g_ch[0].cnt, 6);
    a_rst = 1'b1;
    #1;
    check("async_cnt", dut_a.g_ch[0].cnt, 0);
    check("async_sync", dut_a.g_ch[0].sync, 0);
    check("async_di2", a_di2, 0);
    check("async_chg2", a_chg2, 0);
    @(negedge clk);
    a_rst = 1'b0;
    check("midrst_di1", a_di1, 0);
    repeat (16) @(negedge clk);
    check("midrst16_di1", a_di1, 0);
    check("midrst16_chg1", a_chg1, 0);
    @(negedge clk);
    check("midrst17_di1", a_di1, 1);
    check("midrst17_di2", a_di2, 1);
    check("midrst17_chg1", a_chg1, CHG_EN);

    // DB_LIMIT=1, SYNC_STAGES=3: di1 follows in1 four edges late, chg1 on every change.
    prev_di = 1'b0;
    for (int k = 0; k < 24; k++) begin
      b_in1 = pat(k);
      @(negedge clk);
      exp_di = (k >= 3) ? pat(k - 3) : 1'b0;
      check($sformatf("fast_di1_%0d", k), b_di1, exp_di);
      check($sformatf("fast_chg1_%0d", k), b_chg1, CHG_EN & (exp_di ^ prev_di));
      prev_di = exp_di;
    end
    check("fast_di2", b_di2, 0);
    check("fast_chg2", b_chg2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
